// File: rtl/crossing_scheduler.sv
// rtl/crossing_scheduler.sv - pedestrian-crossing request scheduler: debounced buttons, min green, req/ack, night mode, fault.
module crossing_scheduler #(
    parameter int CLK_PER_TICK    = 50_000_000,
    parameter int MIN_CAR_GREEN   = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a,
    input  logic btn_b,
    input  logic night_mode,
    input  logic cross_ack,
    input  logic cycle_done,
    output logic cross_req,
    output logic wait_a,
    output logic wait_b,
    output logic night_blink,
    output logic fault,
    output logic tick
);
    localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(MIN_CAR_GREEN + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_CROSSING = 3'd2;
    localparam logic [2:0] S_NIGHT    = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    logic [2:0]    state, next_state;
    logic [PW-1:0] presc;
    logic [GW-1:0] green_timer;
    logic [AW-1:0] ack_timer;
    logic [1:0]    sync1, sync2, level, level_q, pending, press;
    logic [DW-1:0] deb_cnt [2];
    logic          green_done, press_ok, enter_clear;

    assign tick   = (presc == PW'(CLK_PER_TICK - 1));
    assign press  = level & ~level_q;
    assign wait_a = pending[0];
    assign wait_b = pending[1];

    // The minimum green is met in the very tick that completes it, not one cycle later.
    assign green_done = (green_timer == GW'(MIN_CAR_GREEN)) ||
                        (tick && (green_timer == GW'(MIN_CAR_GREEN - 1)));
    assign press_ok   = (state == S_IDLE) || (state == S_REQ) || (state == S_FAULT);
    assign enter_clear = (next_state == S_NIGHT) ||
                         ((next_state == S_CROSSING) && (state != S_CROSSING));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (night_mode)
                    next_state = S_NIGHT;
                else if ((|pending) && green_done)
                    next_state = S_REQ;
            end
            S_REQ: begin
                if (cross_ack)
                    next_state = S_CROSSING;
                else if (tick && (ack_timer == AW'(ACK_TIMEOUT - 1)))
                    next_state = S_FAULT;
            end
            S_CROSSING: if (cycle_done) next_state = S_IDLE;
            S_NIGHT:    if (!night_mode) next_state = S_IDLE;
            S_FAULT:    next_state = S_FAULT;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < 2; i++)
                deb_cnt[i] <= '0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            sync1   <= {btn_b, btn_a};
            sync2   <= sync1;
            level_q <= level;
            for (int i = 0; i < 2; i++) begin
                if (!sync2[i]) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= 1'b0;
                end else begin
                    if (deb_cnt[i] != DW'(DEBOUNCE_CYCLES))
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    if (deb_cnt[i] >= DW'(DEBOUNCE_CYCLES - 1))
                        level[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pending     <= '0;
            green_timer <= '0;
            ack_timer   <= '0;
            cross_req   <= 1'b0;
            night_blink <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state <= next_state;
            // Entering a crossing serves both sides; night mode drops any waiting request.
            if (enter_clear)
                pending <= '0;
            else if (press_ok)
                pending <= pending | press;
            if ((next_state == S_IDLE) && (state != S_IDLE))
                green_timer <= '0;
            else if ((state == S_IDLE) && tick && (green_timer != GW'(MIN_CAR_GREEN)))
                green_timer <= green_timer + 1'b1;
            if ((next_state == S_REQ) && (state != S_REQ))
                ack_timer <= '0;
            else if ((state == S_REQ) && tick && !cross_ack)
                ack_timer <= ack_timer + 1'b1;
            cross_req   <= (next_state == S_REQ);
            night_blink <= (next_state == S_NIGHT) || (next_state == S_FAULT);
            fault       <= (next_state == S_FAULT);
        end
    end
endmodule

// File: tb/tb_crossing_scheduler.sv
// tb/tb_crossing_scheduler.sv - directed and randomized self-checking bench for crossing_scheduler.
module tb_crossing_scheduler;
    localparam int CPT = 4;
    localparam int MIN = 3;
    localparam int DEB = 2;
    localparam int TO  = 5;

    logic clk = 1'b0;
    logic rst_n, btn_a, btn_b, night_mode, cross_ack, cycle_done;
    logic cross_req, wait_a, wait_b, night_blink, fault, tick;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    crossing_scheduler #(
        .CLK_PER_TICK(CPT), .MIN_CAR_GREEN(MIN), .DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_a(btn_a), .btn_b(btn_b), .night_mode(night_mode),
        .cross_ack(cross_ack), .cycle_done(cycle_done), .cross_req(cross_req),
        .wait_a(wait_a), .wait_b(wait_b), .night_blink(night_blink), .fault(fault), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn_a = 1'b0; btn_b = 1'b0; night_mode = 1'b0;
        cross_ack = 1'b0; cycle_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, cross_req, wait_a, wait_b, night_blink, fault, tick}, 32'd0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic hold_btn(input logic a, input logic b, input int len);
        btn_a = a; btn_b = b;
        repeat (len) step();
        btn_a = 1'b0; btn_b = 1'b0;
    endtask

    task automatic pulse_ack();
        cross_ack = 1'b1; step(); cross_ack = 1'b0;
    endtask

    task automatic pulse_done();
        cycle_done = 1'b1; step(); cycle_done = 1'b0;
    endtask

    // Reference rule: ticks fall on cycles where cycle mod CPT == CPT-1.
    function automatic int ticks_in(input int first, input int last_excl);
        int n = 0;
        for (int c = first; c < last_excl; c++)
            if (c % CPT == CPT - 1) n++;
        return n;
    endfunction

    initial begin
        int early, rises, seen, len, d, nt;
        logic prev;

        // Reset state and tick cadence.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("tick_c%0d", c), tick, (c % CPT == CPT - 1));
            step();
        end

        // Debounce: a one-cycle glitch is rejected, a held press lands 2+DEB+1 cycles later.
        do_reset();
        hold_btn(1'b1, 1'b0, 1);
        run_to(8);
        chk("glitch_rejected", wait_a, 1'b0);
        btn_a = 1'b1;
        run_to(8 + 2 + DEB);
        chk("press_latency_minus1", wait_a, 1'b0);
        step();
        chk("press_latency", wait_a, 1'b1);
        run_to(18);
        btn_a = 1'b0;

        // Minimum green, ack handshake, presses ignored while crossing.
        do_reset();
        run_to(3);
        hold_btn(1'b0, 1'b1, 4);
        run_to(11);
        chk("mg_no_req_at_3rd_tick", cross_req, 1'b0);
        step();
        chk("mg_req_after_3rd_tick", cross_req, 1'b1);
        chk("mg_wait_b", wait_b, 1'b1);
        pulse_ack();
        chk("ack_drops_req", cross_req, 1'b0);
        chk("ack_clears_wait_b", wait_b, 1'b0);
        hold_btn(1'b1, 1'b0, 4);
        run_to(20);
        chk("crossing_press_ignored", wait_a, 1'b0);
        pulse_done();
        hold_btn(1'b1, 1'b0, 4);
        early = 0;
        while (cyc < 31) begin
            if (cross_req) early = 1;
            step();
        end
        chk("green_restart_no_early_req", early, 0);
        chk("green_restart_no_req_3rd_tick", cross_req, 1'b0);
        step();
        chk("green_restart_req", cross_req, 1'b1);

        // Both sides together: one request serves both.
        do_reset();
        hold_btn(1'b1, 1'b1, 4);
        run_to(12);
        chk("both_req", cross_req, 1'b1);
        chk("both_waits", {wait_a, wait_b}, 2'b11);
        rises = 0; prev = cross_req;
        repeat (2) begin
            step();
            if (cross_req && !prev) rises++;
            prev = cross_req;
        end
        chk("both_single_req", rises, 0);
        pulse_ack();
        chk("both_waits_cleared", {wait_a, wait_b, cross_req}, 3'b000);
        pulse_done();
        seen = 0;
        repeat (20) begin
            if (cross_req) seen = 1;
            step();
        end
        chk("both_no_second_req", seen, 0);

        // Night mode: pre-empts a pending request, blocks presses, restarts full green.
        do_reset();
        hold_btn(1'b1, 1'b0, 4);
        run_to(6);
        chk("night_pre_wait_a", wait_a, 1'b1);
        night_mode = 1'b1;
        step();
        chk("night_blink_on", night_blink, 1'b1);
        chk("night_clears_wait_a", wait_a, 1'b0);
        hold_btn(1'b0, 1'b1, 6);
        run_to(14);
        chk("night_press_ignored", wait_b, 1'b0);
        chk("night_no_req", cross_req, 1'b0);
        run_to(16);
        night_mode = 1'b0;
        step();
        chk("night_exit_blink_off", night_blink, 1'b0);
        hold_btn(1'b1, 1'b0, 4);
        run_to(27);
        chk("night_exit_full_green", cross_req, 1'b0);
        step();
        chk("night_exit_req", cross_req, 1'b1);
        pulse_ack();
        night_mode = 1'b1;
        seen = 0;
        while (cyc < 34) begin
            if (night_blink) seen = 1;
            step();
        end
        pulse_done();
        if (night_blink) seen = 1;
        chk("night_deferred_in_crossing", seen, 0);
        step();
        chk("night_after_cycle_done", night_blink, 1'b1);
        night_mode = 1'b0;

        // Asynchronous reset in the middle of a request.
        do_reset();
        hold_btn(1'b1, 1'b0, 4);
        run_to(13);
        chk("async_pre_req", cross_req, 1'b1);
        #3 rst_n = 1'b0;
        #1 chk("async_rst_req", {cross_req, wait_a}, 2'b00);

        // Acknowledge timeout leads to a sticky fault.
        do_reset();
        hold_btn(1'b1, 1'b0, 4);
        run_to(31);
        chk("to_pre_fault", {fault, cross_req}, 2'b01);
        step();
        chk("to_fault", {fault, night_blink, cross_req, wait_a}, 4'b1101);
        pulse_ack();
        hold_btn(1'b0, 1'b1, 3);
        run_to(40);
        chk("to_sticky", {fault, cross_req}, 2'b10);
        chk("to_press_in_fault", wait_b, 1'b1);
        #3 rst_n = 1'b0;
        #1 chk("to_reset_clears", {fault, night_blink, wait_a, wait_b}, 4'b0000);

        // Randomized button pulse lengths against the debounce rule.
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 4);
            do_reset();
            hold_btn(1'b1, 1'b0, len);
            run_to(10);
            chk($sformatf("rand_deb_len%0d", len), wait_a, (len >= DEB));
        end

        // Randomized ack delay against the timeout rule; the first two sit on the boundary.
        for (int k = 0; k < 6; k++) begin
            d = (k == 0) ? 19 : (k == 1) ? 20 : $urandom_range(0, 24);
            do_reset();
            hold_btn(1'b1, 1'b0, 4);
            run_to(12);
            chk("rand_to_req", cross_req, 1'b1);
            run_to(12 + d);
            nt = ticks_in(12, 12 + d);
            pulse_ack();
            step();
            chk($sformatf("rand_to_fault_d%0d", d), fault, (nt >= TO));
            chk($sformatf("rand_to_req_d%0d", d), cross_req, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
